// File: rtl/tdm_demux4_if.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4_if
// Description : Bundle for the 4-slot TDM demultiplexer: serial input side
//               plus the demultiplexed frame outputs and framing status.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdm_demux4_if #(
  parameter int W = 1
);
  logic [W-1:0] in;
  logic         in_valid;
  logic         frame_sync;
  logic [W-1:0] out0;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic [W-1:0] out3;
  logic         frame_valid;
  logic         s0;
  logic         s1;
  logic         locked;
  logic         sync_err;
  logic [7:0]   frame_count;

  // Stream source / frame consumer side.
  modport master (
    output in,
    output in_valid,
    output frame_sync,
    input  out0,
    input  out1,
    input  out2,
    input  out3,
    input  frame_valid,
    input  s0,
    input  s1,
    input  locked,
    input  sync_err,
    input  frame_count
  );

  // Demultiplexer side.
  modport slave (
    input  in,
    input  in_valid,
    input  frame_sync,
    output out0,
    output out1,
    output out2,
    output out3,
    output frame_valid,
    output s0,
    output s1,
    output locked,
    output sync_err,
    output frame_count
  );
endinterface
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4
// Description : Four-slot TDM demultiplexer with HUNT/RUN frame alignment,
//               shadow capture of partial frames and a frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
  parameter int W = 1
) (
  input  wire           clk,
  input  wire           reset,
  tdm_demux4_if.slave   bus
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [W-1:0] shadow0_q, shadow0_d;
  logic [W-1:0] shadow1_q, shadow1_d;
  logic [W-1:0] shadow2_q, shadow2_d;
  logic [W-1:0] out0_q, out0_d;
  logic [W-1:0] out1_q, out1_d;
  logic [W-1:0] out2_q, out2_d;
  logic [W-1:0] out3_q, out3_d;
  logic         frame_valid_q, frame_valid_d;
  logic         sync_err_q, sync_err_d;
  logic [7:0]   frame_count_q, frame_count_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      shadow2_q     <= '0;
      out0_q        <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      out3_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow0_q     <= shadow0_d;
      shadow1_q     <= shadow1_d;
      shadow2_q     <= shadow2_d;
      out0_q        <= out0_d;
      out1_q        <= out1_d;
      out2_q        <= out2_d;
      out3_q        <= out3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow0_d     = shadow0_q;
    shadow1_d     = shadow1_q;
    shadow2_d     = shadow2_q;
    out0_d        = out0_q;
    out1_d        = out1_q;
    out2_d        = out2_q;
    out3_d        = out3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    frame_count_d = frame_count_q;

    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow0_d = bus.in;
            slot_d    = 2'd1;
            state_d   = RUN;
          end
        end

        RUN: begin
          if (slot_q == 2'd0) begin
            if (bus.frame_sync) begin
              shadow0_d = bus.in;
              slot_d    = 2'd1;
            end else begin
              // Missing sync where a frame must start: alignment is lost.
              sync_err_d = 1'b1;
              slot_d     = 2'd0;
              state_d    = HUNT;
            end
          end else if (bus.frame_sync) begin
            // Early sync: restart the frame here; stale shadow slots are
            // overwritten before they can ever be published.
            sync_err_d = 1'b1;
            shadow0_d  = bus.in;
            slot_d     = 2'd1;
          end else begin
            case (slot_q)
              2'd1: begin
                shadow1_d = bus.in;
                slot_d    = 2'd2;
              end
              2'd2: begin
                shadow2_d = bus.in;
                slot_d    = 2'd3;
              end
              default: begin
                out0_d        = shadow0_q;
                out1_d        = shadow1_q;
                out2_d        = shadow2_q;
                out3_d        = bus.in;
                slot_d        = 2'd0;
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + 8'd1;
              end
            endcase
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.out0        = out0_q;
  assign bus.out1        = out1_q;
  assign bus.out2        = out2_q;
  assign bus.out3        = out3_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.s0          = slot_q[0];
  assign bus.s1          = slot_q[1];
  assign bus.locked      = (state_q == RUN);
  assign bus.frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux4
// Description : Self-checking bench for tdm_demux4 against a frame-level
//               reference model (queue of the partial frame being assembled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tdm_demux4_if #(.W(W)) bus ();

  tdm_demux4 #(.W(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: aligned flag, samples of the frame in progress, last
  // published frame, one-cycle flags and the frame counter.
  bit           m_locked;
  logic [W-1:0] m_part[$];
  logic [W-1:0] m_out[4];
  bit           m_fv;
  bit           m_err;
  int           m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(bit rst, bit v, bit fs, logic [W-1:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_part.delete();
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      m_cnt = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1'b1;
          m_part.delete();
          m_part.push_back(d);
        end
      end else if (m_part.size() == 0) begin
        if (fs) m_part.push_back(d);
        else begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end
      end else if (fs) begin
        m_err = 1'b1;
        m_part.delete();
        m_part.push_back(d);
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_part[i];
          m_part.delete();
          m_fv  = 1'b1;
          m_cnt = (m_cnt + 1) % 256;
        end
      end
    end
  endfunction

  task automatic compare_all();
    int exp_slot;
    exp_slot = m_locked ? m_part.size() : 0;
    check("out0", 32'(bus.out0), 32'(m_out[0]));
    check("out1", 32'(bus.out1), 32'(m_out[1]));
    check("out2", 32'(bus.out2), 32'(m_out[2]));
    check("out3", 32'(bus.out3), 32'(m_out[3]));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    check("sync_err", 32'(bus.sync_err), 32'(m_err));
    check("slot", 32'({bus.s1, bus.s0}), 32'(exp_slot));
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("frame_count", 32'(bus.frame_count), 32'(m_cnt));
  endtask

  task automatic step(input bit rst, input bit v, input bit fs, input logic [W-1:0] d);
    @(negedge clk);
    reset          = rst;
    bus.in_valid   = v;
    bus.frame_sync = fs;
    bus.in         = d;
    @(posedge clk);
    model_edge(rst, v, fs, d);
    #1;
    compare_all();
  endtask

  task automatic frame(input logic [W-1:0] a, b, c, e);
    step(1'b0, 1'b1, 1'b1, a);
    step(1'b0, 1'b1, 1'b0, b);
    step(1'b0, 1'b1, 1'b0, c);
    step(1'b0, 1'b1, 1'b0, e);
  endtask

  initial begin
    int pos;
    bit v, fs, rst;
    reset          = 1'b1;
    bus.in         = '0;
    bus.in_valid   = 1'b0;
    bus.frame_sync = 1'b0;

    // Reset, with live inputs to show reset wins.
    step(1'b1, 1'b1, 1'b1, 4'hF);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Basic frame 1,0,0,0.
    frame(4'h1, 4'h0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check("basic_count", 32'(bus.frame_count), 32'd1);

    // Gap of two idle cycles between slots 1 and 2.
    step(1'b0, 1'b1, 1'b1, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h1);
    step(1'b0, 1'b0, 1'b1, 4'h7);
    step(1'b0, 1'b0, 1'b0, 4'h9);
    step(1'b0, 1'b1, 1'b0, 4'h1);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Early sync on slot 2.
    step(1'b0, 1'b1, 1'b1, 4'hA);
    step(1'b0, 1'b1, 1'b0, 4'hB);
    step(1'b0, 1'b1, 1'b1, 4'hC);
    frame(4'h0, 4'h0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Missing sync at slot 0, then ignored samples while hunting.
    frame(4'h3, 4'h4, 4'h5, 4'h6);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    frame(4'h2, 4'h4, 4'h6, 4'h8);

    // 256 back-to-back frames: counter wraps to its starting value.
    pos = m_cnt;
    for (int f = 0; f < 256; f++)
      frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    check("wrap_count", 32'(bus.frame_count), 32'(pos));

    // Reset after slot 2, then a clean restart.
    step(1'b0, 1'b1, 1'b1, 4'h9);
    step(1'b0, 1'b1, 1'b0, 4'h9);
    step(1'b0, 1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b1, 1'b0, 4'h9);
    check("rst_mid_out3", 32'(bus.out3), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h9);
    frame(4'hE, 4'hD, 4'hC, 4'hB);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Randomized traffic: mostly well-framed with injected faults.
    pos = 0;
    for (int n = 0; n < 3000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      fs  = (pos == 0) ^ ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(rst, v, fs, 4'($urandom));
      if (rst) pos = 0;
      else if (v) pos = (pos + 1) % 4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
